// File: rtl/l1_cache4w.sv
// l1_cache4w: 4-way set-associative write-back, write-allocate L1 data cache with PLRU replacement
module l1_cache4w #(
    parameter int READ_HIT_LAT   = 1,
    parameter int WRITE_HIT_TPUT = 1,
    parameter int MM_WRITE_TPUT  = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  a,
    input  logic [3:0]   be,
    input  logic         read,
    input  logic         write,
    input  logic [31:0]  wd,
    input  logic         ram_test,
    output logic [31:0]  rd,
    output logic         rd_valid,
    output logic         req_hit,
    output logic         req_miss,
    output logic         req_mod,
    output logic [31:0]  mm_a,
    output logic [255:0] mm_wd,
    output logic         mm_write,
    output logic         mm_read,
    output logic [31:0]  mm_be,
    input  logic [255:0] mm_rd,
    input  logic         mm_readdata_valid
);
    typedef enum logic [2:0] {IDLE, WB, FILL, WAIT, INSTALL} state_t;

    state_t        state;
    logic [3:0]    v_bits   [256];
    logic [3:0]    m_bits   [256];
    logic [2:0]    lru_bits [256];
    logic [13:0]   tag_mem  [256][4];
    logic [255:0]  data_mem [256][4];
    logic [255:0]  fill_buf;
    logic [1:0]    vic;
    logic [7:0]    line_idx;
    logic [13:0]   line_tag;
    logic [7:0]    mw_cnt;
    logic [7:0]    wh_cnt;
    logic [READ_HIT_LAT-1:0] vq;
    logic [31:0]   dq [READ_HIT_LAT];

    logic [7:0]    idx;
    logic [13:0]   tg;
    logic [2:0]    wsel;
    logic [3:0]    hv;
    logic [1:0]    hw;
    logic [1:0]    plru;
    logic [1:0]    vic_c;
    logic          vic_dirty;
    logic [2:0]    lru_nxt;
    logic [31:0]   word;
    logic [31:0]   merged;
    logic          idle;
    logic          hit;
    logic          rd_hit;
    logic          wr_hit;
    logic          unused_bits;

    assign unused_bits = ^{a[31:27], a[1:0]};
    assign rd          = dq[READ_HIT_LAT-1];
    assign rd_valid    = vq[READ_HIT_LAT-1];

    // Tag compare, victim choice, PLRU next state and byte merge for the current request
    always_comb begin
        idx  = a[12:5];
        tg   = a[26:13];
        wsel = a[4:2];
        for (int i = 0; i < 4; i++) hv[i] = v_bits[idx][i] && tag_mem[idx][i] == tg;
        hw        = hv[0] ? 2'd0 : hv[1] ? 2'd1 : hv[2] ? 2'd2 : 2'd3;
        plru      = lru_bits[idx][2] ? {1'b1, lru_bits[idx][1]} : {1'b0, lru_bits[idx][0]};
        vic_c     = !v_bits[idx][0] ? 2'd0 : !v_bits[idx][1] ? 2'd1 : !v_bits[idx][2] ? 2'd2 : !v_bits[idx][3] ? 2'd3 : plru;
        vic_dirty = v_bits[idx][vic_c] && m_bits[idx][vic_c];
        lru_nxt   = hw[1] ? {1'b0, ~hw[0], lru_bits[idx][0]} : {1'b1, lru_bits[idx][1], ~hw[0]};
        word      = data_mem[idx][hw][{wsel, 5'b0} +: 32];
        for (int i = 0; i < 4; i++) merged[8*i +: 8] = be[i] ? wd[8*i +: 8] : word[8*i +: 8];
        idle     = state == IDLE && wh_cnt == 8'd0;
        hit      = (read || write) && |hv;
        req_hit  = idle && hit;
        req_miss = (read || write) && !req_hit;
        req_mod  = req_miss && vic_dirty;
        rd_hit   = req_hit && read;
        wr_hit   = req_hit && write && !read;
    end

    // Tag/data arrays and fill buffer; left unreset because the valid bits qualify them
    always_ff @(posedge clk) begin
        if (!ram_test) begin
            if ((state == FILL || state == WAIT) && mm_readdata_valid) fill_buf <= mm_rd;
            if (state == INSTALL) begin
                tag_mem[line_idx][vic]  <= line_tag;
                data_mem[line_idx][vic] <= fill_buf;
            end else if (wr_hit) begin
                data_mem[idx][hw][{wsel, 5'b0} +: 32] <= merged;
            end
        end
    end

    // Read-hit pipeline: a sampled hit emerges on rd/rd_valid READ_HIT_LAT cycles later
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vq <= '0;
            for (int i = 0; i < READ_HIT_LAT; i++) dq[i] <= '0;
        end else begin
            vq <= (READ_HIT_LAT)'({vq, rd_hit && !ram_test});
            if (rd_hit && !ram_test) dq[0] <= word;
            for (int i = 1; i < READ_HIT_LAT; i++) dq[i] <= dq[i-1];
        end
    end

    // Miss FSM, valid/mod/PLRU bookkeeping and the registered memory interface
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            mm_a     <= '0;
            mm_wd    <= '0;
            mm_write <= 1'b0;
            mm_read  <= 1'b0;
            mm_be    <= '0;
            mw_cnt   <= '0;
            wh_cnt   <= '0;
            vic      <= '0;
            line_idx <= '0;
            line_tag <= '0;
            for (int i = 0; i < 256; i++) begin
                v_bits[i]   <= '0;
                m_bits[i]   <= '0;
                lru_bits[i] <= '0;
            end
        end else if (!ram_test) begin
            if (wh_cnt != 8'd0) wh_cnt <= wh_cnt - 8'd1;
            case (state)
                IDLE: begin
                    if (rd_hit || wr_hit) lru_bits[idx] <= lru_nxt;
                    if (wr_hit) begin
                        m_bits[idx][hw] <= 1'b1;
                        wh_cnt          <= 8'(WRITE_HIT_TPUT - 1);
                    end
                    if (idle && req_miss) begin
                        vic      <= vic_c;
                        line_idx <= idx;
                        line_tag <= tg;
                        mw_cnt   <= '0;
                        if (vic_dirty) begin
                            state    <= WB;
                            mm_write <= 1'b1;
                            mm_be    <= '1;
                            mm_a     <= {5'b0, tag_mem[idx][vic_c], idx, 5'b0};
                            mm_wd    <= data_mem[idx][vic_c];
                        end else begin
                            state   <= FILL;
                            mm_read <= 1'b1;
                            mm_a    <= {5'b0, tg, idx, 5'b0};
                        end
                    end
                end
                WB: begin
                    if (mw_cnt == 8'(MM_WRITE_TPUT - 1)) begin
                        mm_write <= 1'b0;
                        mm_be    <= '0;
                        mm_read  <= 1'b1;
                        mm_a     <= {5'b0, line_tag, line_idx, 5'b0};
                        state    <= FILL;
                    end else begin
                        mw_cnt <= mw_cnt + 8'd1;
                    end
                end
                FILL, WAIT: begin
                    if (mm_readdata_valid) begin
                        mm_read <= 1'b0;
                        state   <= INSTALL;
                    end else begin
                        state <= WAIT;
                    end
                end
                INSTALL: begin
                    v_bits[line_idx][vic] <= 1'b1;
                    m_bits[line_idx][vic] <= 1'b0;
                    state                 <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_l1_cache4w.sv
// tb_l1_cache4w: directed table-driven bench for l1_cache4w with a small line-memory model
module tb_l1_cache4w;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  a = '0;
    logic [3:0]   be = '0;
    logic         read = 1'b0;
    logic         write = 1'b0;
    logic [31:0]  wd = '0;
    logic         ram_test = 1'b0;
    logic [31:0]  rd;
    logic         rd_valid;
    logic         req_hit;
    logic         req_miss;
    logic         req_mod;
    logic [31:0]  mm_a;
    logic [255:0] mm_wd;
    logic         mm_write;
    logic         mm_read;
    logic [31:0]  mm_be;
    logic [255:0] mm_rd;
    logic         mm_readdata_valid;

    int total = 0;
    int bad = 0;
    int fill_n = 0;
    int wb_n = 0;
    int dly = 0;
    logic [31:0]  fill_a = '0;
    logic [31:0]  wb_a = '0;
    logic [31:0]  wb_w1 = '0;
    logic         mem_hold = 1'b0;
    logic [255:0] mem [logic [31:0]];

    typedef struct packed {
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        hit;
        logic        mod;
        logic [31:0] rdx;
        logic [3:0]  fills;
        logic [31:0] fa;
        logic [3:0]  wbs;
        logic [31:0] wa;
        logic [31:0] ww1;
        logic [10:0] st;
    } vec_t;

    vec_t vt [12];
    vec_t post;

    always #5 clk = ~clk;

    l1_cache4w dut (
        .clk(clk), .reset(reset), .a(a), .be(be), .read(read), .write(write), .wd(wd),
        .ram_test(ram_test), .rd(rd), .rd_valid(rd_valid), .req_hit(req_hit), .req_miss(req_miss),
        .req_mod(req_mod), .mm_a(mm_a), .mm_wd(mm_wd), .mm_write(mm_write), .mm_read(mm_read),
        .mm_be(mm_be), .mm_rd(mm_rd), .mm_readdata_valid(mm_readdata_valid)
    );

    function automatic logic [255:0] pat(input logic [31:0] la);
        logic [255:0] p;
        for (int k = 0; k < 8; k++) p[32*k +: 32] = la | (32'(k) << 28);
        return p;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", nm, got, exp);
        end
    endtask

    function automatic logic [10:0] set_state(input logic [7:0] s);
        return {dut.v_bits[s], dut.m_bits[s], dut.lru_bits[s]};
    endfunction

    task automatic apply(input vec_t v, input string tg);
        int f0, w0;
        logic h0, m0, d0, done, wh;
        logic [31:0] got;
        f0 = fill_n;
        w0 = wb_n;
        read = v.r; write = v.w; a = v.a; be = v.be; wd = v.wd;
        #1;
        h0 = req_hit; m0 = req_miss; d0 = req_mod;
        done = 1'b0;
        got = '0;
        for (int n = 0; n < 200 && !done; n++) begin
            wh = v.w && !v.r && req_hit;
            @(posedge clk);
            #1;
            if (wh) done = 1'b1;
            else if (v.r && rd_valid) begin
                done = 1'b1;
                got = rd;
            end
        end
        read = 1'b0; write = 1'b0;
        chk({tg, "_done"}, 32'(done), 32'd1);
        chk({tg, "_hit"}, 32'(h0), 32'(v.hit));
        chk({tg, "_miss"}, 32'(m0), 32'(!v.hit));
        chk({tg, "_mod"}, 32'(d0), 32'(v.mod));
        if (v.r) chk({tg, "_rd"}, got, v.rdx);
        else chk({tg, "_no_rdv"}, 32'(rd_valid), 32'd0);
        chk({tg, "_fills"}, 32'(fill_n - f0), 32'(v.fills));
        if (v.fills != 0) chk({tg, "_fill_a"}, fill_a, v.fa);
        chk({tg, "_wbs"}, 32'(wb_n - w0), 32'(v.wbs));
        if (v.wbs != 0) begin
            chk({tg, "_wb_a"}, wb_a, v.wa);
            chk({tg, "_wb_w1"}, wb_w1, v.ww1);
        end
        chk({tg, "_set"}, 32'(set_state(v.a[12:5])), 32'(v.st));
    endtask

    initial begin
        mm_readdata_valid = 1'b0;
        mm_rd = '0;
        forever begin
            @(negedge clk);
            if (mm_write) begin
                wb_n++;
                wb_a = mm_a;
                wb_w1 = mm_wd[63:32];
                mem[mm_a] = mm_wd;
                chk("wb_be", mm_be, 32'hFFFFFFFF);
                chk("wb_excl", 32'(mm_read), 32'd0);
            end
            if (mm_readdata_valid) mm_readdata_valid = 1'b0;
            else if (mm_read && !mem_hold) begin
                dly++;
                if (dly == 3) begin
                    dly = 0;
                    mm_rd = mem.exists(mm_a) ? mem[mm_a] : pat(mm_a);
                    mm_readdata_valid = 1'b1;
                    fill_n++;
                    fill_a = mm_a;
                end
            end else dly = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vt[0]  = '{1'b1, 1'b0, 32'h000020A4, 4'h0, 32'h0,         1'b0, 1'b0, 32'h100020A0, 4'd1, 32'h000020A0, 4'd0, 32'h0,         32'h0,         11'h085};
        vt[1]  = '{1'b1, 1'b0, 32'h000040A8, 4'h0, 32'h0,         1'b0, 1'b0, 32'h200040A0, 4'd1, 32'h000040A0, 4'd0, 32'h0,         32'h0,         11'h184};
        vt[2]  = '{1'b1, 1'b0, 32'h000060AC, 4'h0, 32'h0,         1'b0, 1'b0, 32'h300060A0, 4'd1, 32'h000060A0, 4'd0, 32'h0,         32'h0,         11'h382};
        vt[3]  = '{1'b1, 1'b0, 32'h000080A0, 4'h0, 32'h0,         1'b0, 1'b0, 32'h000080A0, 4'd1, 32'h000080A0, 4'd0, 32'h0,         32'h0,         11'h780};
        vt[4]  = '{1'b1, 1'b0, 32'h0000A0A0, 4'h0, 32'h0,         1'b0, 1'b0, 32'h0000A0A0, 4'd1, 32'h0000A0A0, 4'd0, 32'h0,         32'h0,         11'h785};
        vt[5]  = '{1'b0, 1'b1, 32'h000060A4, 4'hC, 32'hCAFEF00D,  1'b1, 1'b0, 32'h0,         4'd0, 32'h0,         4'd0, 32'h0,         32'h0,         11'h7A3};
        vt[6]  = '{1'b1, 1'b0, 32'h000080A0, 4'h0, 32'h0,         1'b1, 1'b0, 32'h000080A0, 4'd0, 32'h0,         4'd0, 32'h0,         32'h0,         11'h7A1};
        vt[7]  = '{1'b1, 1'b0, 32'h000040A8, 4'h0, 32'h0,         1'b1, 1'b0, 32'h200040A0, 4'd0, 32'h0,         4'd0, 32'h0,         32'h0,         11'h7A4};
        vt[8]  = '{1'b0, 1'b1, 32'h0000C0A4, 4'h5, 32'h11223344,  1'b0, 1'b1, 32'h0,         4'd1, 32'h0000C0A0, 4'd4, 32'h000060A0, 32'hCAFE60A0, 11'h7A2};
        vt[9]  = '{1'b1, 1'b1, 32'h0000C0A4, 4'hF, 32'hFFFFFFFF,  1'b1, 1'b0, 32'h1022C044, 4'd0, 32'h0,         4'd0, 32'h0,         32'h0,         11'h7A2};
        vt[10] = '{1'b1, 1'b0, 32'h0000C0A4, 4'h0, 32'h0,         1'b1, 1'b0, 32'h1022C044, 4'd0, 32'h0,         4'd0, 32'h0,         32'h0,         11'h7A2};
        vt[11] = '{1'b1, 1'b0, 32'h000060A4, 4'h0, 32'h0,         1'b0, 1'b0, 32'hCAFE60A0, 4'd1, 32'h000060A0, 4'd0, 32'h0,         32'h0,         11'h7A7};
        post   = '{1'b1, 1'b0, 32'h000060A4, 4'h0, 32'h0,         1'b0, 1'b0, 32'hCAFE60A0, 4'd1, 32'h000060A0, 4'd0, 32'h0,         32'h0,         11'h085};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd", rd, 32'h0);
        chk("rst_rdv", 32'(rd_valid), 32'd0);
        chk("rst_mm_read", 32'(mm_read), 32'd0);
        chk("rst_mm_write", 32'(mm_write), 32'd0);
        chk("rst_mm_a", mm_a, 32'h0);
        chk("rst_mm_be", mm_be, 32'h0);
        chk("rst_req", 32'({req_hit, req_miss, req_mod}), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) apply(vt[i], $sformatf("v%0d", i));

        ram_test = 1'b1;
        read = 1'b1;
        a = 32'h0000C0A4;
        #1;
        chk("rt_hit", 32'(req_hit), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("rt_no_rdv", 32'(rd_valid), 32'd0);
        a = 32'h00000120;
        #1;
        chk("rt_miss", 32'(req_miss), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("rt_no_mm_read", 32'(mm_read), 32'd0);
        read = 1'b0;
        ram_test = 1'b0;
        chk("rt_set5", 32'(set_state(8'd5)), 32'h7A7);

        mem_hold = 1'b1;
        read = 1'b1;
        a = 32'h00000100;
        for (int n = 0; n < 10 && !mm_read; n++) begin
            @(posedge clk);
            #1;
        end
        chk("rs_issue", 32'(mm_read), 32'd1);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("rs_mm_read", 32'(mm_read), 32'd0);
        chk("rs_mm_write", 32'(mm_write), 32'd0);
        chk("rs_set5", 32'(set_state(8'd5)), 32'h0);
        chk("rs_set8", 32'(set_state(8'd8)), 32'h0);
        read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        mem_hold = 1'b0;
        @(posedge clk);
        #1;
        apply(post, "post");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
